mem_bus_fabric: RTL and testbench

//  Parametrised successor to the SoC's hard-wired address-bit peripheral select. It connects one native

---
 rtl/mem_bus_pkg.sv | 21 ++
 rtl/mem_bus_addr_decode.sv | 35 +++
 rtl/mem_bus_fabric.sv | 180 ++++++++++++++++++
 tb/tb_mem_bus_fabric.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus fabric.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_DECODE  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEADBEEF;

  // Index width for a slave select; a single slave still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_addr_decode.sv
// Combinational base/mask window matcher; the lowest-index matching slave wins.
module mem_bus_addr_decode
  import mem_bus_pkg::*;
#(
  parameter int                       NUM_SLAVES = 6,
  parameter int                       SEL_W      = sel_width(NUM_SLAVES),
  parameter logic [NUM_SLAVES*32-1:0] SLV_BASE   = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*32-1:0] SLV_MASK   = {NUM_SLAVES{32'hFFF00000}}
) (
  input  logic [31:0]           addr,
  output logic                  hit,
  output logic [SEL_W-1:0]      sel,
  output logic [NUM_SLAVES-1:0] onehot
);

  logic [NUM_SLAVES-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      match[i] = ((addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]);
    end
  end

  always_comb begin
    hit = |match;
    sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) sel = SEL_W'(i);
    end
    // Isolate the lowest set bit so overlapping windows resolve to one slave.
    onehot = match & (~match + NUM_SLAVES'(1));
  end

endmodule

// File: rtl/mem_bus_fabric.sv
// One valid/ready master to NUM_SLAVES windowed slaves, with registered response
// path, access timeout and a sticky first-error record.
//
// state  | meaning
// IDLE   | waiting for a master request (blocked for one cycle after RESP)
// ACCESS | selected slave requested, timeout counter running
// RESP   | one-cycle m_ready pulse with read data or ERR_RDATA
module mem_bus_fabric
  import mem_bus_pkg::*;
#(
  parameter int                       NUM_SLAVES  = 6,
  parameter int                       DATA_W      = 32,
  parameter logic [NUM_SLAVES*32-1:0] SLV_BASE    = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*32-1:0] SLV_MASK    = {NUM_SLAVES{32'hFFF00000}},
  parameter int                       TIMEOUT_CYC = 255,
  parameter logic [DATA_W-1:0]        ERR_RDATA   = DATA_W'(ERR_RDATA_DEF)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_valid,
  input  logic [31:0]                  m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  input  logic [DATA_W/8-1:0]          m_wstrb,
  output logic                         m_ready,
  output logic [DATA_W-1:0]            m_rdata,
  output logic [NUM_SLAVES-1:0]        s_valid,
  output logic [31:0]                  s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_wstrb,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  output logic                         err_irq,
  output logic [31:0]                  err_addr,
  output logic [1:0]                   err_code,
  input  logic                         err_clr
);

  localparam int              SEL_W    = sel_width(NUM_SLAVES);
  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  bus_state_t              state_q, state_d;
  logic                    dec_hit;
  logic [SEL_W-1:0]        dec_sel;
  logic [NUM_SLAVES-1:0]   dec_onehot;
  logic [SEL_W-1:0]        sel_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    resp_blk_q;
  logic                    slv_ready;
  logic [DATA_W-1:0]       rdata_sel;

  logic                    accept;
  logic                    access_ok;
  logic                    access_to;
  logic                    err_event;
  logic [1:0]              err_code_new;
  logic [31:0]             err_addr_new;

  mem_bus_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_decode (
    .addr   (m_addr),
    .hit    (dec_hit),
    .sel    (dec_sel),
    .onehot (dec_onehot)
  );

  // s_valid is one-hot on the selected slave, so it masks out stray readies.
  assign slv_ready = |(s_ready & s_valid);

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) rdata_sel = s_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = dec_hit ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (access_ok || access_to) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept       = 1'b0;
    access_ok    = 1'b0;
    access_to    = 1'b0;
    err_event    = 1'b0;
    err_code_new = ERR_NONE;
    err_addr_new = s_addr;
    case (state_q)
      ST_IDLE: begin
        accept = m_valid && !resp_blk_q;
        if (accept && !dec_hit) begin
          err_event    = 1'b1;
          err_code_new = ERR_DECODE;
          err_addr_new = m_addr;
        end
      end
      ST_ACCESS: begin
        // A ready arriving in the last counted cycle still wins over the timeout.
        access_ok = slv_ready;
        access_to = !slv_ready && (cnt_q == CNT_LAST);
        if (access_to) begin
          err_event    = 1'b1;
          err_code_new = ERR_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_addr  <= '0;
      s_wdata <= '0;
      s_wstrb <= '0;
      sel_q   <= '0;
      s_valid <= '0;
    end else if (accept) begin
      s_addr  <= m_addr;
      s_wdata <= m_wdata;
      s_wstrb <= m_wstrb;
      sel_q   <= dec_sel;
      s_valid <= dec_onehot;
    end else if (access_ok || access_to) begin
      s_valid <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       cnt_q <= '0;
    else if (state_q == ST_ACCESS) cnt_q <= cnt_q + CNT_W'(1);
    else                           cnt_q <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready    <= 1'b0;
      m_rdata    <= '0;
      resp_blk_q <= 1'b0;
    end else begin
      m_ready    <= (state_d == ST_RESP);
      resp_blk_q <= (state_q == ST_RESP);
      if (access_ok && (s_wstrb == '0)) m_rdata <= rdata_sel;
      else if (state_d == ST_RESP)      m_rdata <= ERR_RDATA;
      else                              m_rdata <= '0;
    end
  end

  // First error is sticky until cleared; a clear coinciding with a new error keeps the new one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_irq  <= 1'b0;
      err_addr <= '0;
      err_code <= ERR_NONE;
    end else if (err_event && (!err_irq || err_clr)) begin
      err_irq  <= 1'b1;
      err_addr <= err_addr_new;
      err_code <= err_code_new;
    end else if (err_clr) begin
      err_irq  <= 1'b0;
      err_addr <= '0;
      err_code <= ERR_NONE;
    end
  end

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Directed and randomized accesses against a transaction-level model of the fabric.
module tb_mem_bus_fabric;

  localparam int N  = 6;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam logic [N*32-1:0] BASE = {32'h0050_0000, 32'h0040_0000, 32'h0000_0000,
                                      32'h0020_0000, 32'h0010_0000, 32'h0000_0000};
  localparam logic [N*32-1:0] MASK = {32'hFFF0_0000, 32'hFFF0_0000, 32'hFFE0_0000,
                                      32'hFFF0_0000, 32'hFFF0_0000, 32'hFFF0_0000};
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          m_valid = 1'b0;
  logic [31:0]   m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [3:0]    m_wstrb = '0;
  logic          m_ready;
  logic [DW-1:0] m_rdata;
  logic [N-1:0]  s_valid;
  logic [31:0]   s_addr;
  logic [DW-1:0] s_wdata;
  logic [3:0]    s_wstrb;
  logic [N-1:0]  s_ready = '0;
  logic [N*DW-1:0] s_rdata = '0;
  logic          err_irq;
  logic [31:0]   err_addr;
  logic [1:0]    err_code;
  logic          err_clr = 1'b0;

  int tests = 0;
  int fails = 0;

  // Error-record model
  bit          md_irq = 1'b0;
  logic [31:0] md_addr = '0;
  logic [1:0]  md_code = '0;

  always #5 clk = ~clk;

  mem_bus_fabric #(
    .NUM_SLAVES  (N),
    .DATA_W      (DW),
    .SLV_BASE    (BASE),
    .SLV_MASK    (MASK),
    .TIMEOUT_CYC (TO),
    .ERR_RDATA   (ERRD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_valid  (m_valid),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_ready  (m_ready),
    .m_rdata  (m_rdata),
    .s_valid  (s_valid),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_ready  (s_ready),
    .s_rdata  (s_rdata),
    .err_irq  (err_irq),
    .err_addr (err_addr),
    .err_code (err_code),
    .err_clr  (err_clr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Window rule: first slave i with (addr & mask_i) == base_i, else -1.
  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < N; i++) begin
      if ((a & MASK[i*32 +: 32]) == BASE[i*32 +: 32]) return i;
    end
    return -1;
  endfunction

  task automatic check_err(input string tag);
    check({tag, "_err_irq"},  err_irq,  md_irq);
    check({tag, "_err_addr"}, err_addr, md_addr);
    check({tag, "_err_code"}, err_code, md_code);
  endtask

  // One master transaction; the bench plays the slave, raising ready on the
  // selected slave in its (dly+1)-th request cycle and random stray readies elsewhere.
  task automatic access(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                        input int dly, input bit clr, input string tag);
    int          sel, cyc, svc, exp_cyc, exp_svc;
    bit          got, miss, tmo, err;
    logic [31:0] rd, exp_rd;
    logic [N-1:0] oh;
    sel  = ref_decode(addr);
    miss = (sel < 0);
    tmo  = !miss && (dly >= TO);
    err  = miss || tmo;
    rd   = $urandom;
    exp_rd  = (err || ws != 4'd0) ? ERRD : rd;
    exp_cyc = miss ? 1 : (tmo ? TO + 1 : dly + 2);
    exp_svc = miss ? 0 : (tmo ? TO : dly + 1);
    oh      = miss ? '0 : (N'(1) << sel);
    @(negedge clk);
    m_valid = 1'b1;
    m_addr  = addr;
    m_wdata = wd;
    m_wstrb = ws;
    err_clr = clr;
    s_ready = '0;
    s_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    if (!miss) s_rdata[sel*32 +: 32] = rd;
    cyc = 0;
    svc = 0;
    got = 1'b0;
    while (!got && cyc < TO + 6) begin
      @(negedge clk);
      cyc++;
      err_clr = 1'b0;
      if (m_ready) begin
        got = 1'b1;
        check({tag, "_rdata"}, m_rdata, exp_rd);
      end else if (s_valid != '0) begin
        svc++;
        check({tag, "_s_valid"}, s_valid, oh);
        check({tag, "_s_addr"},  s_addr,  addr);
        check({tag, "_s_wdata"}, s_wdata, wd);
        check({tag, "_s_wstrb"}, s_wstrb, ws);
        s_ready = N'($urandom);
        if (!miss) s_ready[sel] = (svc == dly + 1);
      end
    end
    check({tag, "_got_ready"}, got, 1'b1);
    check({tag, "_latency"}, cyc, exp_cyc);
    check({tag, "_s_valid_cycles"}, svc, exp_svc);
    if (clr) begin
      md_irq  = 1'b0;
      md_addr = '0;
      md_code = '0;
    end
    if (err && !md_irq) begin
      md_irq  = 1'b1;
      md_addr = addr;
      md_code = miss ? 2'd1 : 2'd2;
    end
    check_err(tag);
    m_valid = 1'b0;
    s_ready = '0;
    @(negedge clk);
    check({tag, "_ready_pulse"}, m_ready, 1'b0);
  endtask

  task automatic clear_err(input string tag);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    md_irq  = 1'b0;
    md_addr = '0;
    md_code = '0;
    check_err(tag);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          k, pick;
    logic [2:0]  slots [5];
    slots[0] = 3'd0; slots[1] = 3'd1; slots[2] = 3'd2; slots[3] = 3'd4; slots[4] = 3'd5;

    // Reset values
    #1 rst = 1'b1;
    #2;
    check("rst_m_ready",  m_ready,  1'b0);
    check("rst_m_rdata",  m_rdata,  32'h0);
    check("rst_s_valid",  s_valid,  6'h0);
    check("rst_s_addr",   s_addr,   32'h0);
    check("rst_s_wstrb",  s_wstrb,  4'h0);
    check("rst_err_irq",  err_irq,  1'b0);
    check("rst_err_addr", err_addr, 32'h0);
    check("rst_err_code", err_code, 2'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Read from slave 2 with immediate ready
    access(32'h0020_0040, 32'h0, 4'h0, 0, 1'b0, "t1_rd_s2");
    // Write to slave 0 with a delayed ready
    access(32'h0000_0100, 32'h1234_5678, 4'b0011, 5, 1'b0, "t2_wr_s0");
    // Unmapped address
    access(32'hF000_0000, 32'h0, 4'h0, 0, 1'b0, "t3_miss");
    clear_err("t3_clr");
    // Timeouts: the second one must not overwrite the first record
    access(32'h0010_0008, 32'h0, 4'h0, TO + 3, 1'b0, "t4_tmo1");
    access(32'h0040_0010, 32'h0, 4'h0, TO + 3, 1'b0, "t4_tmo2");
    clear_err("t4_clr");
    // Ready in the final counted cycle, then overlapping windows 0 and 3
    access(32'h0050_0004, 32'h0, 4'h0, TO - 1, 1'b0, "t5_ready_at_limit");
    access(32'h0000_0010, 32'h0, 4'h0, 1, 1'b0, "t5_overlap");
    // Clear coinciding with a new error keeps the new error
    access(32'h9000_0000, 32'h0, 4'h0, 0, 1'b0, "t5_miss_a");
    access(32'hA000_0004, 32'h0, 4'h0, 0, 1'b1, "t5_miss_clr");

    // Reset in the middle of an access
    @(negedge clk);
    m_valid = 1'b1;
    m_addr  = 32'h0010_0020;
    m_wstrb = 4'h0;
    @(negedge clk);
    check("t6_pre_rst_s_valid", s_valid, 6'b000010);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_s_valid",  s_valid,  6'h0);
    check("t6_rst_s_addr",   s_addr,   32'h0);
    check("t6_rst_m_ready",  m_ready,  1'b0);
    check("t6_rst_err_irq",  err_irq,  1'b0);
    check("t6_rst_err_code", err_code, 2'd0);
    m_valid = 1'b0;
    md_irq  = 1'b0;
    md_addr = '0;
    md_code = '0;
    @(negedge clk);
    rst = 1'b0;
    access(32'h0010_0020, 32'h0, 4'h0, 2, 1'b0, "t6_after_rst");

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 4);
      if (pick == 0) begin
        a = 32'h8000_0000 | 32'($urandom);
      end else begin
        k = $urandom_range(0, 4);
        a = {9'h0, slots[k], 20'($urandom)};
      end
      access(a, $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
             $urandom_range(0, TO + 2), ($urandom_range(0, 5) == 0), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
